// File: rtl/ipv4_lut_arbiter_pkg.sv
// rtl/ipv4_lut_arbiter_pkg.sv - shared FSM encodings, default widths and counter sizing for the IPv4 LUT arbiter
package ipv4_lut_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DP_WAIT   = 2'd1,
        ST_MGMT_WAIT = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_ENTRY_WIDTH = 64;
    localparam int DEF_STARVE_MAX  = 8;
    localparam int DEF_TIMEOUT     = 16;
    localparam int KEY_WIDTH       = 32;
    localparam int STAT_WIDTH      = 32;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ipv4_lut_arb_stats.sv
// rtl/ipv4_lut_arb_stats.sv - saturating event counters for datapath results, mgmt acks and timeouts
module ipv4_lut_arb_stats
    import ipv4_lut_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_dp_i,
    input  logic                  inc_mgmt_i,
    input  logic                  inc_tmo_i,
    output logic [STAT_WIDTH-1:0] dp_cnt_o,
    output logic [STAT_WIDTH-1:0] mgmt_cnt_o,
    output logic [STAT_WIDTH-1:0] tmo_cnt_o
);

    logic [STAT_WIDTH-1:0] dp_cnt_q, mgmt_cnt_q, tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_cnt_q   <= '0;
            mgmt_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (inc_dp_i && (dp_cnt_q != '1))
                dp_cnt_q <= dp_cnt_q + 1'b1;
            if (inc_mgmt_i && (mgmt_cnt_q != '1))
                mgmt_cnt_q <= mgmt_cnt_q + 1'b1;
            if (inc_tmo_i && (tmo_cnt_q != '1))
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign dp_cnt_o   = dp_cnt_q;
    assign mgmt_cnt_o = mgmt_cnt_q;
    assign tmo_cnt_o  = tmo_cnt_q;

endmodule

// File: rtl/ipv4_lut_arbiter.sv
// rtl/ipv4_lut_arbiter.sv - single-port IPv4 FIB arbiter between datapath lookups and mgmt accesses
// Optional statistics counters are built when IPV4_LUT_ARB_STATS_EN is defined.
module ipv4_lut_arbiter
    import ipv4_lut_arbiter_pkg::*;
#(
    parameter int C_ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int C_ENTRY_WIDTH = DEF_ENTRY_WIDTH,
    parameter int C_STARVE_MAX  = DEF_STARVE_MAX,
    parameter int C_TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dp_valid,
    input  logic [KEY_WIDTH-1:0]     dp_daddr,
    output logic                     dp_rd,
    output logic                     dp_res_valid,
    output logic                     dp_res_hit,
    output logic [C_ENTRY_WIDTH-1:0] dp_res_data,
    output logic                     dp_res_tmo,
    input  logic                     mgmt_req,
    input  logic                     mgmt_wr,
    input  logic [C_ADDR_WIDTH-1:0]  mgmt_addr,
    input  logic [C_ENTRY_WIDTH-1:0] mgmt_wdata,
    output logic                     mgmt_ack,
    output logic [C_ENTRY_WIDTH-1:0] mgmt_rdata,
    output logic                     mgmt_tmo,
    output logic                     lut_req,
    output logic                     lut_wr,
    output logic [KEY_WIDTH-1:0]     lut_key,
    output logic [C_ADDR_WIDTH-1:0]  lut_addr,
    output logic [C_ENTRY_WIDTH-1:0] lut_wdata,
    input  logic                     lut_ack,
    input  logic                     lut_hit,
    input  logic [C_ENTRY_WIDTH-1:0] lut_rdata
`ifdef IPV4_LUT_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]    stat_dp_cnt,
    output logic [STAT_WIDTH-1:0]    stat_mgmt_cnt,
    output logic [STAT_WIDTH-1:0]    stat_tmo_cnt
`endif
);

    localparam int SW = cnt_width(C_STARVE_MAX);
    localparam int TW = cnt_width(C_TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(C_STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(C_TIMEOUT - 1);

    arb_state_e               state_q, state_d;
    logic [SW-1:0]            starve_q, starve_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     lut_wr_q, lut_wr_d;
    logic [KEY_WIDTH-1:0]     key_q, key_d;
    logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [C_ENTRY_WIDTH-1:0] wdata_q, wdata_d;
    logic                     res_v_q, res_v_d, res_hit_q, res_hit_d, res_tmo_q, res_tmo_d;
    logic [C_ENTRY_WIDTH-1:0] res_data_q, res_data_d;
    logic                     mack_q, mack_d, mtmo_q, mtmo_d;
    logic [C_ENTRY_WIDTH-1:0] mrdata_q, mrdata_d;
    logic                     dp_rd_c, mgmt_pend, done, abort;

    // The requester still holds mgmt_req during its ack cycle; ignore it there.
    assign mgmt_pend = mgmt_req & ~mack_q;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        lut_wr_d   = lut_wr_q;
        key_d      = key_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        res_v_d    = 1'b0;
        res_hit_d  = 1'b0;
        res_tmo_d  = 1'b0;
        res_data_d = '0;
        mack_d     = 1'b0;
        mtmo_d     = 1'b0;
        mrdata_d   = '0;
        dp_rd_c    = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (mgmt_pend && (!dp_valid || (starve_q == STARVE_LIM))) begin
                    state_d  = ST_MGMT_WAIT;
                    lut_wr_d = mgmt_wr;
                    addr_d   = mgmt_addr;
                    wdata_d  = mgmt_wdata;
                    starve_d = '0;
                end else if (dp_valid) begin
                    dp_rd_c  = 1'b1;
                    state_d  = ST_DP_WAIT;
                    lut_wr_d = 1'b0;
                    key_d    = dp_daddr;
                    starve_d = mgmt_pend ? starve_q + 1'b1 : '0;
                end
            end
            ST_DP_WAIT, ST_MGMT_WAIT: begin
                if (lut_ack)
                    done = 1'b1;
                else if (tmo_q == TMO_LAST)
                    abort = 1'b1;
                else
                    tmo_d = tmo_q + 1'b1;
                if (done || abort) begin
                    state_d  = ST_IDLE;
                    lut_wr_d = 1'b0;
                    if (state_q == ST_DP_WAIT) begin
                        res_v_d    = 1'b1;
                        res_tmo_d  = abort;
                        res_hit_d  = done & lut_hit;
                        res_data_d = (done && lut_hit) ? lut_rdata : '0;
                    end else begin
                        mack_d   = 1'b1;
                        mtmo_d   = abort;
                        mrdata_d = (done && !lut_wr_q) ? lut_rdata : '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            tmo_q      <= '0;
            lut_wr_q   <= 1'b0;
            key_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            res_v_q    <= 1'b0;
            res_hit_q  <= 1'b0;
            res_tmo_q  <= 1'b0;
            res_data_q <= '0;
            mack_q     <= 1'b0;
            mtmo_q     <= 1'b0;
            mrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            lut_wr_q   <= lut_wr_d;
            key_q      <= key_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            res_v_q    <= res_v_d;
            res_hit_q  <= res_hit_d;
            res_tmo_q  <= res_tmo_d;
            res_data_q <= res_data_d;
            mack_q     <= mack_d;
            mtmo_q     <= mtmo_d;
            mrdata_q   <= mrdata_d;
        end
    end

    // The pop is combinational, so it must not fire while the FIFOs are being reset.
    assign dp_rd        = dp_rd_c & ~reset;
    assign dp_res_valid = res_v_q;
    assign dp_res_hit   = res_hit_q;
    assign dp_res_tmo   = res_tmo_q;
    assign dp_res_data  = res_data_q;
    assign mgmt_ack     = mack_q;
    assign mgmt_tmo     = mtmo_q;
    assign mgmt_rdata   = mrdata_q;
    assign lut_req      = (state_q != ST_IDLE);
    assign lut_wr       = lut_wr_q;
    assign lut_key      = key_q;
    assign lut_addr     = addr_q;
    assign lut_wdata    = wdata_q;

`ifdef IPV4_LUT_ARB_STATS_EN
    ipv4_lut_arb_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .inc_dp_i   (res_v_q),
        .inc_mgmt_i (mack_q),
        .inc_tmo_i  (res_tmo_q | mtmo_q),
        .dp_cnt_o   (stat_dp_cnt),
        .mgmt_cnt_o (stat_mgmt_cnt),
        .tmo_cnt_o  (stat_tmo_cnt)
    );
`endif

endmodule

// File: tb/tb_ipv4_lut_arbiter.sv
// tb/tb_ipv4_lut_arbiter.sv - self-checking bench for ipv4_lut_arbiter with a cycle-level reference model
module tb_ipv4_lut_arbiter;

    localparam int SMAX = 8;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        dp_valid;
    logic [31:0] dp_daddr;
    logic        dp_rd, dp_res_valid, dp_res_hit, dp_res_tmo;
    logic [63:0] dp_res_data;
    logic        mgmt_req, mgmt_wr;
    logic [4:0]  mgmt_addr;
    logic [63:0] mgmt_wdata;
    logic        mgmt_ack, mgmt_tmo;
    logic [63:0] mgmt_rdata;
    logic        lut_req, lut_wr;
    logic [31:0] lut_key;
    logic [4:0]  lut_addr;
    logic [63:0] lut_wdata;
    logic        lut_ack = 1'b0;
    logic        lut_hit = 1'b0;
    logic [63:0] lut_rdata = '0;
`ifdef IPV4_LUT_ARB_STATS_EN
    logic [31:0] stat_dp_cnt, stat_mgmt_cnt, stat_tmo_cnt;
`endif

    always #5 clk = ~clk;

    ipv4_lut_arbiter dut (
        .clk(clk), .reset(reset),
        .dp_valid(dp_valid), .dp_daddr(dp_daddr), .dp_rd(dp_rd),
        .dp_res_valid(dp_res_valid), .dp_res_hit(dp_res_hit),
        .dp_res_data(dp_res_data), .dp_res_tmo(dp_res_tmo),
        .mgmt_req(mgmt_req), .mgmt_wr(mgmt_wr), .mgmt_addr(mgmt_addr),
        .mgmt_wdata(mgmt_wdata), .mgmt_ack(mgmt_ack), .mgmt_rdata(mgmt_rdata),
        .mgmt_tmo(mgmt_tmo),
        .lut_req(lut_req), .lut_wr(lut_wr), .lut_key(lut_key), .lut_addr(lut_addr),
        .lut_wdata(lut_wdata), .lut_ack(lut_ack), .lut_hit(lut_hit), .lut_rdata(lut_rdata)
`ifdef IPV4_LUT_ARB_STATS_EN
        , .stat_dp_cnt(stat_dp_cnt), .stat_mgmt_cnt(stat_mgmt_cnt), .stat_tmo_cnt(stat_tmo_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Table responder: ack delay chosen per access; -1 selects a random delay.
    int          force_dly = 0;
    logic        force_data_en = 1'b0;
    logic [63:0] force_data = '0;
    logic        spur_en = 1'b0;
    logic        late_ack = 1'b0;
    int          r_age = 0;
    int          r_dly = 0;

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 15);
        if (r < 10) return $urandom_range(0, 3);
        if (r < 13) return $urandom_range(4, 15);
        if (r == 13) return TMO - 1;
        if (r == 14) return 99;
        return TMO;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (lut_req) begin
            if (r_age == 0) r_dly = (force_dly >= 0) ? force_dly : pick_dly();
            lut_ack = (r_age == r_dly);
            r_age++;
        end else begin
            r_age = 0;
            lut_ack = late_ack || (spur_en && ($urandom_range(0, 7) == 0));
        end
        if (force_data_en) begin
            lut_hit   = 1'b1;
            lut_rdata = force_data;
        end else begin
            lut_hit   = 1'($urandom_range(0, 1));
            lut_rdata = {$urandom, $urandom};
        end
    end

    // Reference model: phase 0 idle, 1 datapath access, 2 mgmt access.
    logic        cmp_en = 1'b0;
    int          m_phase = 0, m_age = 0, m_starve = 0;
    logic        e_rv = 0, e_hit = 0, e_tmo = 0, e_mack = 0, e_mtmo = 0, e_lwr = 0;
    logic [63:0] e_data = '0, e_mrd = '0, e_wdata = '0;
    logic [31:0] e_key = '0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_sdp = '0, e_smg = '0, e_stm = '0;

    always @(negedge clk) begin : model_cmp
        logic mp, g_m, g_d;
        mp  = mgmt_req && !e_mack;
        g_m = (m_phase == 0) && mp && (!dp_valid || (m_starve == SMAX));
        g_d = (m_phase == 0) && !g_m && dp_valid;
        if (cmp_en) begin
            chk("dp_rd", dp_rd, g_d && !reset);
            chk("dp_result", {dp_res_valid, dp_res_hit, dp_res_tmo, dp_res_data},
                {e_rv, e_hit, e_tmo, e_data});
            chk("mgmt_result", {mgmt_ack, mgmt_tmo, mgmt_rdata}, {e_mack, e_mtmo, e_mrd});
            chk("lut_if", {lut_req, lut_wr, lut_key, lut_addr, lut_wdata},
                {m_phase != 0, e_lwr, e_key, e_addr, e_wdata});
`ifdef IPV4_LUT_ARB_STATS_EN
            chk("stats", {stat_dp_cnt, stat_mgmt_cnt, stat_tmo_cnt}, {e_sdp, e_smg, e_stm});
`endif
        end
        if (reset) begin
            m_phase = 0; m_age = 0; m_starve = 0;
            e_rv = 0; e_hit = 0; e_tmo = 0; e_data = '0; e_mack = 0; e_mtmo = 0; e_mrd = '0;
            e_lwr = 0; e_key = '0; e_addr = '0; e_wdata = '0;
            e_sdp = '0; e_smg = '0; e_stm = '0;
        end else begin
            if (e_rv && e_sdp != 32'hffffffff) e_sdp = e_sdp + 1;
            if (e_mack && e_smg != 32'hffffffff) e_smg = e_smg + 1;
            if ((e_tmo || e_mtmo) && e_stm != 32'hffffffff) e_stm = e_stm + 1;
            e_rv = 0; e_hit = 0; e_tmo = 0; e_data = '0; e_mack = 0; e_mtmo = 0; e_mrd = '0;
            if (m_phase == 0) begin
                if (g_m) begin
                    m_phase = 2; m_age = 0; m_starve = 0;
                    e_lwr = mgmt_wr; e_addr = mgmt_addr; e_wdata = mgmt_wdata;
                end else if (g_d) begin
                    m_phase = 1; m_age = 0;
                    m_starve = mp ? m_starve + 1 : 0;
                    e_lwr = 0; e_key = dp_daddr;
                end
            end else if (lut_ack) begin
                if (m_phase == 1) begin
                    e_rv = 1; e_hit = lut_hit; e_data = lut_hit ? lut_rdata : '0;
                end else begin
                    e_mack = 1; e_mrd = e_lwr ? '0 : lut_rdata;
                end
                m_phase = 0; e_lwr = 0;
            end else begin
                m_age++;
                if (m_age == TMO) begin
                    if (m_phase == 1) begin e_rv = 1; e_tmo = 1; end
                    else begin e_mack = 1; e_mtmo = 1; end
                    m_phase = 0; e_lwr = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        #1000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
    end

    logic rd_prev;
    logic m_idle;
    int   n_dp, n_req;
    logic done, seen_res;

    task automatic dp_access(input logic [31:0] a);
        tick(); dp_valid = 1'b1; dp_daddr = a;
        tick(); dp_valid = 1'b0;
        repeat (TMO + 4) tick();
    endtask

    initial begin
        reset = 1'b1; dp_valid = 1'b0; dp_daddr = '0;
        mgmt_req = 1'b0; mgmt_wr = 1'b0; mgmt_addr = '0; mgmt_wdata = '0;
        tick();
        cmp_en = 1'b1;
        #2;
        chk("rst_state", {lut_req, dp_res_valid, mgmt_ack, dp_rd, lut_wr}, 5'b0);
        tick(); reset = 1'b0;

        // Basic lookup: pop at T, request at T+1, result at T+2.
        force_dly = 0; force_data_en = 1'b1; force_data = 64'h55;
        tick(); dp_valid = 1'b1; dp_daddr = 32'h0a000001;
        #2 chk("t_dp_rd", dp_rd, 1'b1);
        tick(); dp_valid = 1'b0;
        #2 chk("t_dp_req", {lut_req, lut_wr, lut_key}, {1'b1, 1'b0, 32'h0a000001});
        tick();
        #2 chk("t_dp_res", {dp_res_valid, dp_res_hit, dp_res_tmo, dp_res_data}, {3'b110, 64'h55});

        // Mgmt write with no datapath traffic.
        tick(); mgmt_req = 1'b1; mgmt_wr = 1'b1; mgmt_addr = 5'd3; mgmt_wdata = 64'hAB;
        #2 chk("t_mg_nodp", dp_rd, 1'b0);
        tick();
        #2 chk("t_mg_req", {lut_req, lut_wr, lut_addr, lut_wdata, mgmt_ack}, {2'b11, 5'd3, 64'hAB, 1'b0});
        tick(); mgmt_req = 1'b0;
        #2 chk("t_mg_ack", {mgmt_ack, mgmt_tmo}, 2'b10);

        // Starvation limit: SMAX datapath grants, one mgmt grant, then datapath resumes.
        force_data_en = 1'b0;
        tick(); dp_valid = 1'b1; dp_daddr = $urandom;
        mgmt_req = 1'b1; mgmt_wr = 1'b1; mgmt_addr = 5'd7; mgmt_wdata = {$urandom, $urandom};
        n_dp = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #2;
            rd_prev = dp_rd;
            if (mgmt_ack) begin
                chk("t_starve_resume", dp_rd, 1'b1);
                done = 1'b1;
            end else if (rd_prev) n_dp++;
            tick();
            if (rd_prev) dp_daddr = $urandom;
            if (done) begin mgmt_req = 1'b0; dp_valid = 1'b0; end
        end
        chk("t_starve_done", done, 1'b1);
        chk("t_starve_grants", n_dp, SMAX);
        repeat (4) tick();

        // Timeout: no ack ever; then a late ack must be ignored.
        force_dly = 99;
        tick(); dp_valid = 1'b1; dp_daddr = 32'hc0a80001;
        #2 chk("t_tmo_rd", dp_rd, 1'b1);
        tick(); dp_valid = 1'b0;
        #2;
        n_req = 0;
        while (lut_req && n_req < 40) begin
            n_req++;
            tick();
            #2;
        end
        chk("t_tmo_len", n_req, TMO);
        chk("t_tmo_res", {dp_res_valid, dp_res_tmo, dp_res_hit, dp_res_data}, {3'b110, 64'h0});
        late_ack = 1'b1;
        tick();
        #2 late_ack = 1'b0;
        tick();
        #2 chk("t_late_ack", {dp_res_valid, mgmt_ack, lut_req}, 3'b000);

        // Reset while waiting: access discarded, no result afterwards.
        tick(); dp_valid = 1'b1; dp_daddr = 32'h01020304;
        tick(); dp_valid = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        #2 chk("t_rst_mid", {lut_req, dp_res_valid, dp_rd, lut_key, mgmt_ack}, 36'h0);
        seen_res = 1'b0;
        for (int c = 0; c < TMO + 8; c++) begin
            tick();
            #2 if (dp_res_valid) seen_res = 1'b1;
        end
        chk("t_rst_nores", seen_res, 1'b0);

`ifdef IPV4_LUT_ARB_STATS_EN
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        force_dly = 1;
        dp_access(32'h0a000002);
        dp_access(32'h0a000003);
        tick(); mgmt_req = 1'b1; mgmt_wr = 1'b0; mgmt_addr = 5'd9;
        tick(); tick(); tick();
        #2 if (mgmt_ack) begin tick(); mgmt_req = 1'b0; end else begin tick(); mgmt_req = 1'b0; end
        repeat (4) tick();
        force_dly = 99;
        dp_access(32'h0a000004);
        repeat (3) tick();
        chk("t_stats", {stat_dp_cnt, stat_mgmt_cnt, stat_tmo_cnt}, {32'd3, 32'd1, 32'd1});
`endif

        // Randomized traffic checked cycle by cycle against the model.
        force_dly = -1; spur_en = 1'b1; force_data_en = 1'b0;
        m_idle = 1'b1; rd_prev = 1'b0; mgmt_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 499) == 0);
            if (rd_prev) begin
                dp_valid = ($urandom_range(0, 2) != 0);
                dp_daddr = $urandom;
            end else if (!dp_valid) begin
                dp_valid = ($urandom_range(0, 2) == 0);
                dp_daddr = $urandom;
            end
            if (mgmt_ack) begin
                mgmt_req = 1'($urandom_range(0, 1));
                m_idle = 1'b1;
            end else if (m_idle) begin
                if ($urandom_range(0, 3) == 0) begin
                    mgmt_req = 1'b1; m_idle = 1'b0;
                    mgmt_wr = 1'($urandom_range(0, 1));
                    mgmt_addr = 5'($urandom_range(0, 31));
                    mgmt_wdata = {$urandom, $urandom};
                end else mgmt_req = 1'b0;
            end
            #2 rd_prev = dp_rd;
        end
        tick(); reset = 1'b0; dp_valid = 1'b0; mgmt_req = 1'b0;
        repeat (TMO + 4) tick();
        summary();
    end

endmodule
